// File: rtl/reg_ctx_engine.sv
// rtl/reg_ctx_engine.sv - register-file context save/restore engine (optional checksum via REG_CTX_CHECKSUM_EN)
module reg_ctx_engine #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_save,
    input  logic              start_restore,
    input  logic              abort,
    output logic              busy,
    output logic              done,
`ifdef REG_CTX_CHECKSUM_EN
    output logic              chk_err,
`endif
    output logic [ADDR_W-1:0] rf_rs,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_rw,
    output logic              rf_wr,
    output logic [DATA_W-1:0] so_data,
    output logic              so_valid,
    input  logic              so_ready,
    output logic              so_last,
    input  logic [DATA_W-1:0] si_data,
    input  logic              si_valid,
    output logic              si_ready
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SAVE_ADDR = 3'd1,
        SAVE_CAP  = 3'd2,
        SAVE_OUT  = 3'd3,
        RESTORE   = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   rf_rs_q, rf_rs_d;
    logic [ADDR_W-1:0]   rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]   rf_rw_q, rf_rw_d;
    logic                rf_wr_q, rf_wr_d;
    logic [DATA_W-1:0]   so_data_q, so_data_d;
    logic                so_valid_q, so_valid_d;
    logic                so_last_q, so_last_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
`ifdef REG_CTX_CHECKSUM_EN
    // Running sum of words moved so far; chk_phase marks the trailing checksum word.
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                chk_phase_q, chk_phase_d;
    logic                chk_err_q, chk_err_d;
`endif

    // State and registered outputs; reset abandons any partial transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            rf_rs_q     <= '0;
            rf_rd_q     <= '0;
            rf_rw_q     <= '0;
            rf_wr_q     <= 1'b0;
            so_data_q   <= '0;
            so_valid_q  <= 1'b0;
            so_last_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef REG_CTX_CHECKSUM_EN
            sum_q       <= '0;
            chk_phase_q <= 1'b0;
            chk_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rf_rs_q     <= rf_rs_d;
            rf_rd_q     <= rf_rd_d;
            rf_rw_q     <= rf_rw_d;
            rf_wr_q     <= rf_wr_d;
            so_data_q   <= so_data_d;
            so_valid_q  <= so_valid_d;
            so_last_q   <= so_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef REG_CTX_CHECKSUM_EN
            sum_q       <= sum_d;
            chk_phase_q <= chk_phase_d;
            chk_err_q   <= chk_err_d;
`endif
        end
    end

    // Next-state and next-output decode; abort overrides the sequencing but not a scheduled write.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rf_rs_d     = rf_rs_q;
        rf_rd_d     = rf_rd_q;
        rf_rw_d     = rf_rw_q;
        rf_wr_d     = 1'b0;
        so_data_d   = so_data_q;
        so_valid_d  = so_valid_q;
        so_last_d   = so_last_q;
`ifdef REG_CTX_CHECKSUM_EN
        sum_d       = sum_q;
        chk_phase_d = chk_phase_q;
        chk_err_d   = chk_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_save || start_restore) begin
                    state_d = start_save ? SAVE_ADDR : RESTORE;
                    idx_d   = '0;
                    rf_rs_d = '0;
`ifdef REG_CTX_CHECKSUM_EN
                    sum_d       = '0;
                    chk_phase_d = 1'b0;
                    chk_err_d   = 1'b0;
`endif
                end
            end
            SAVE_ADDR: begin
                state_d = SAVE_CAP;
            end
            SAVE_CAP: begin
                // The file's read port is registered, so R[idx] is visible this cycle.
                so_data_d  = rf_rdata;
                so_valid_d = 1'b1;
`ifdef REG_CTX_CHECKSUM_EN
                so_last_d  = 1'b0;
                sum_d      = sum_q + rf_rdata;
`else
                so_last_d  = (idx_q == LAST_IDX);
`endif
                state_d    = SAVE_OUT;
            end
            SAVE_OUT: begin
                if (so_ready) begin
                    so_valid_d = 1'b0;
                    so_last_d  = 1'b0;
`ifdef REG_CTX_CHECKSUM_EN
                    if (chk_phase_q) begin
                        state_d = DONE;
                    end else if (idx_q == LAST_IDX) begin
                        // Follow the last register word directly with the checksum word.
                        so_data_d   = sum_q;
                        so_valid_d  = 1'b1;
                        so_last_d   = 1'b1;
                        chk_phase_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        rf_rs_d = idx_q + IDX_ONE;
                        state_d = SAVE_ADDR;
                    end
`else
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        rf_rs_d = idx_q + IDX_ONE;
                        state_d = SAVE_ADDR;
                    end
`endif
                end
            end
            RESTORE: begin
                if (si_valid) begin
`ifdef REG_CTX_CHECKSUM_EN
                    if (chk_phase_q) begin
                        chk_err_d = (si_data != sum_q);
                        state_d   = DONE;
                    end else begin
                        rf_wr_d = 1'b1;
                        rf_rd_d = idx_q;
                        rf_rw_d = si_data;
                        sum_d   = sum_q + si_data;
                        if (idx_q == LAST_IDX) begin
                            chk_phase_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end
`else
                    rf_wr_d = 1'b1;
                    rf_rd_d = idx_q;
                    rf_rw_d = si_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            so_valid_d = 1'b0;
            so_last_d  = 1'b0;
        end

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rf_rs    = rf_rs_q;
    assign rf_rd    = rf_rd_q;
    assign rf_rw    = rf_rw_q;
    assign rf_wr    = rf_wr_q;
    assign so_data  = so_data_q;
    assign so_valid = so_valid_q;
    assign so_last  = so_last_q;
    assign si_ready = (state_q == RESTORE);
`ifdef REG_CTX_CHECKSUM_EN
    assign chk_err  = chk_err_q;
`endif

endmodule

// File: tb/tb_reg_ctx_engine.sv
// tb/tb_reg_ctx_engine.sv - scoreboard testbench for reg_ctx_engine
module tb_reg_ctx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_save, start_restore, abort;
    logic        busy, done;
    logic [3:0]  rf_rs, rf_rd;
    logic [15:0] rf_rdata, rf_rw;
    logic        rf_wr;
    logic [15:0] so_data;
    logic        so_valid, so_ready, so_last;
    logic [15:0] si_data;
    logic        si_valid, si_ready;
`ifdef REG_CTX_CHECKSUM_EN
    logic        chk_err;
`endif

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    int          wq_addr[$];
    logic [15:0] wq_data[$];

    // Register file model: registered read, write on rf_wr, plus a bench preload port.
    logic [15:0] mem [16];
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (rf_wr) mem[rf_rd] <= rf_rw;
        rf_rdata <= mem[rf_rs];
    end

    reg_ctx_engine dut (
        .clk(clk),
        .rst(rst),
        .start_save(start_save),
        .start_restore(start_restore),
        .abort(abort),
        .busy(busy),
        .done(done),
`ifdef REG_CTX_CHECKSUM_EN
        .chk_err(chk_err),
`endif
        .rf_rs(rf_rs),
        .rf_rdata(rf_rdata),
        .rf_rd(rf_rd),
        .rf_rw(rf_rw),
        .rf_wr(rf_wr),
        .so_data(so_data),
        .so_valid(so_valid),
        .so_ready(so_ready),
        .so_last(so_last),
        .si_data(si_data),
        .si_valid(si_valid),
        .si_ready(si_ready)
    );

    task automatic preload(input logic [15:0] base);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 4'(i); ld_data = base + 16'(i);
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({busy, done, so_valid, so_last, rf_wr, si_ready} !== 6'b0 || so_data !== 16'h0 ||
            rf_rs !== 4'h0 || rf_rd !== 4'h0 || rf_rw !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b so_valid=%b so_last=%b rf_wr=%b si_ready=%b so_data=%h rf_rs=%h rf_rd=%h rf_rw=%h, required all 0",
                     busy, done, so_valid, so_last, rf_wr, si_ready, so_data, rf_rs, rf_rd, rf_rw);
        end
`ifdef REG_CTX_CHECKSUM_EN
        tests++;
        if (chk_err !== 1'b0) begin fails++; $display("FAIL reset_chk_err: got %b required 0", chk_err); end
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || si_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b si_ready=%b required 0 0", busy, si_ready);
        end
    endtask

    task automatic run_save(input string name, input logic [15:0] base, input bit both,
                            input int stall_idx, input int stall_len, input bit chk_timing);
        int          cyc = 0;
        int          widx = 0;
        int          stall_left = stall_len;
        int          last_cyc = -1;
        int          done_cnt = 0;
        bit          fin = 0;
        logic [15:0] sum = 16'h0;
        logic [15:0] got;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(base + 16'(i));
            sum = sum + base + 16'(i);
        end
`ifdef REG_CTX_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        so_ready = 1'b1;
        @(negedge clk);
        start_save = 1'b1; start_restore = both;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start_save = 1'b0; start_restore = 1'b0;
            if (both && rf_wr !== 1'b0) begin
                tests++; fails++;
                $display("FAIL %s_no_write: rf_wr=%b required 0 at cycle %0d", name, rf_wr, cyc);
            end
            if (done === 1'b1) done_cnt++;
            if (so_valid === 1'b1 && widx == stall_idx && stall_left > 0 && exp_q.size() > 0) begin
                so_ready = 1'b0;
                stall_left--;
                tests++;
                if (so_data !== exp_q[0]) begin
                    fails++;
                    $display("FAIL %s_stall_hold: so_data=%h required %h", name, so_data, exp_q[0]);
                end
            end else begin
                so_ready = 1'b1;
            end
            if (so_valid === 1'b1 && so_ready === 1'b1 && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                tests++;
                if (so_data !== got) begin
                    fails++;
                    $display("FAIL %s_data[%0d]: so_data=%h required %h", name, widx, so_data, got);
                end
                tests++;
                if (so_last !== (exp_q.size() == 0)) begin
                    fails++;
                    $display("FAIL %s_last[%0d]: so_last=%b required %b", name, widx, so_last, exp_q.size() == 0);
                end
                if (chk_timing && widx == 15) begin
                    tests++;
                    if (cyc != 48) begin
                        fails++;
                        $display("FAIL %s_latency: last register word at cycle %0d required 48", name, cyc);
                    end
                end
                widx++;
                if (exp_q.size() == 0) last_cyc = cyc;
            end else if (last_cyc >= 0 && cyc == last_cyc + 1) begin
                tests++;
                if (done !== 1'b1) begin
                    fails++;
                    $display("FAIL %s_done_timing: done=%b required 1 one cycle after last handshake", name, done);
                end
                fin = 1;
            end
        end
        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL %s_timeout: %0d words left after %0d cycles, required 0", name, exp_q.size(), cyc);
        end
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        tests++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_done_once: done pulses=%0d busy=%b required 1 and 0", name, done_cnt, busy);
        end
        if (stall_len > 0) begin
            tests++;
            if (stall_left != 0) begin
                fails++;
                $display("FAIL %s_stall_cycles: %0d stall cycles not observed, required 0", name, stall_left);
            end
        end
        so_ready = 1'b1;
    endtask

    task automatic run_restore(input string name, input logic [15:0] base, input logic [15:0] old_base,
                               input int abort_after, input bit bad_chk);
        int          n_words = 16;
        int          n_writes;
        int          cyc = 0;
        int          sent = 0;
        int          wcount = 0;
        int          first_w = -1;
        int          last_w = -1;
        int          done_cnt = 0;
        int          abort_cyc = -1;
        int          ea;
        bit          fin = 0;
        logic [15:0] sum = 16'h0;
        logic [15:0] ed;
`ifdef REG_CTX_CHECKSUM_EN
        n_words = 17;
`endif
        n_writes = (abort_after > 0) ? abort_after : 16;
        wq_addr.delete(); wq_data.delete();
        for (int i = 0; i < n_writes; i++) begin
            wq_addr.push_back(i);
            wq_data.push_back(base + 16'(i));
        end
        for (int i = 0; i < 16; i++) sum = sum + base + 16'(i);
        @(negedge clk);
        start_restore = 1'b1;
        while (!fin && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_restore = 1'b0; abort = 1'b0; si_valid = 1'b0;
            if (rf_wr === 1'b1) begin
                tests++;
                if (wq_addr.size() == 0) begin
                    fails++;
                    $display("FAIL %s_unexpected_write: rf_wr=1 rf_rd=%h, required no write", name, rf_rd);
                end else begin
                    ea = wq_addr.pop_front();
                    ed = wq_data.pop_front();
                    if (rf_rd !== 4'(ea) || rf_rw !== ed) begin
                        fails++;
                        $display("FAIL %s_write: rf_rd=%h rf_rw=%h required %h %h", name, rf_rd, rf_rw, 4'(ea), ed);
                    end
                end
                wcount++;
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
            end
            if (done === 1'b1) begin
                done_cnt++;
`ifdef REG_CTX_CHECKSUM_EN
                tests++;
                if (chk_err !== bad_chk) begin
                    fails++;
                    $display("FAIL %s_chk_err: chk_err=%b required %b", name, chk_err, bad_chk);
                end
`endif
                fin = 1;
            end
            if (abort_after > 0 && sent == abort_after && abort_cyc < 0) begin
                abort = 1'b1;
                abort_cyc = cyc;
            end else if (abort_cyc >= 0) begin
                if (cyc == abort_cyc + 1) begin
                    tests++;
                    if (busy !== 1'b0) begin
                        fails++;
                        $display("FAIL %s_abort_busy: busy=%b required 0 after abort", name, busy);
                    end
                end
                if (cyc == abort_cyc + 6) fin = 1;
            end else if (si_ready === 1'b1 && sent < n_words) begin
                si_valid = 1'b1;
                si_data = (sent < 16) ? base + 16'(sent) : (bad_chk ? 16'h0000 : sum);
                sent++;
            end
        end
        si_valid = 1'b0; abort = 1'b0;
        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL %s_timeout: no completion after %0d cycles, required completion", name, cyc);
        end
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (rf_wr === 1'b1) wcount++;
        end
        tests++;
        if (done_cnt != ((abort_after > 0) ? 0 : 1)) begin
            fails++;
            $display("FAIL %s_done_count: done pulses=%0d required %0d", name, done_cnt, (abort_after > 0) ? 0 : 1);
        end
        tests++;
        if (wcount != n_writes || wq_addr.size() != 0 || (last_w - first_w) != n_writes - 1) begin
            fails++;
            $display("FAIL %s_write_count: writes=%0d span=%0d pending=%0d required %0d consecutive",
                     name, wcount, last_w - first_w, wq_addr.size(), n_writes);
        end
        if (abort_after > 0) begin
            tests++;
            if (mem[abort_after - 1] !== base + 16'(abort_after - 1) || mem[abort_after] !== old_base + 16'(abort_after) ||
                mem[15] !== old_base + 16'd15) begin
                fails++;
                $display("FAIL %s_regs: R%0d=%h R%0d=%h R15=%h required %h %h %h", name, abort_after - 1,
                         mem[abort_after - 1], abort_after, mem[abort_after], mem[15],
                         base + 16'(abort_after - 1), old_base + 16'(abort_after), old_base + 16'd15);
            end
        end else begin
            tests++;
            if (mem[5] !== base + 16'd5 || mem[15] !== base + 16'd15) begin
                fails++;
                $display("FAIL %s_readback: R5=%h R15=%h required %h %h", name, mem[5], mem[15], base + 16'd5, base + 16'd15);
            end
        end
    endtask

    task automatic test_save();
        preload(16'h1000);
        run_save("save", 16'h1000, 1'b0, -1, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        run_save("backpressure", 16'h1000, 1'b0, 3, 5, 1'b0);
    endtask

    task automatic test_restore();
        run_restore("restore", 16'hA000, 16'h1000, 0, 1'b0);
    endtask

    task automatic test_simultaneous();
        run_save("simul", 16'hA000, 1'b1, -1, 0, 1'b0);
    endtask

    task automatic test_abort();
        run_restore("abort", 16'hB000, 16'hA000, 7, 1'b0);
        run_restore("after_abort", 16'hC000, 16'hB000, 0, 1'b0);
    endtask

    task automatic test_reset_mid_save();
        int cyc = 0;
        so_ready = 1'b0;
        @(negedge clk);
        start_save = 1'b1;
        @(negedge clk);
        start_save = 1'b0;
        while (so_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (so_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midreset_setup: so_valid=%b busy=%b required 1 1", so_valid, busy);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (so_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midreset_async: so_valid=%b busy=%b done=%b required 0 0 0", so_valid, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        so_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, so_valid, so_last, rf_wr, si_ready} !== 6'b0 || so_data !== 16'h0 || rf_rs !== 4'h0) begin
            fails++;
            $display("FAIL midreset_idle: busy=%b done=%b so_valid=%b so_last=%b rf_wr=%b si_ready=%b so_data=%h rf_rs=%h required all 0",
                     busy, done, so_valid, so_last, rf_wr, si_ready, so_data, rf_rs);
        end
    endtask

`ifdef REG_CTX_CHECKSUM_EN
    task automatic test_checksum();
        preload(16'h1000);
        run_save("chk_save", 16'h1000, 1'b0, -1, 0, 1'b1);
        run_restore("chk_bad", 16'hD000, 16'h1000, 0, 1'b1);
        run_restore("chk_good", 16'hA000, 16'hD000, 0, 1'b0);
    endtask
`endif

    initial begin
        rst = 1'b0;
        start_save = 1'b0; start_restore = 1'b0; abort = 1'b0;
        so_ready = 1'b1; si_valid = 1'b0; si_data = 16'h0;
        test_reset();
        test_save();
        test_backpressure();
        test_restore();
        test_simultaneous();
        test_abort();
        test_reset_mid_save();
`ifdef REG_CTX_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
